chess_cursor_ctrl: RTL and testbench

- Input front end for the chess board: conditions the four direction keys and the lock switch, and runs the board cursor and select/move state machine.
- Presents cursor, selection and select-type information, plus a move request (from/to squares) on a valid/ready handshake.
- Sits directly upstream of the layout-matrix stage, which consumes these outputs to update the 64-square layout that feeds the renderer.

---
 rtl/chess_cursor_ctrl.sv | 111 +++++++++++
 tb/tb_chess_cursor_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/chess_cursor_ctrl.sv
// chess_cursor_ctrl: debounced key/lock front end driving the board cursor and select/move handshake
module chess_cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter logic [5:0] CURSOR_INIT = 6'd0
) (
  input  logic       clock,
  input  logic       resetApp,
  input  logic       enable,
  input  logic       KeyLeft,
  input  logic       KeyUp,
  input  logic       KeyDown,
  input  logic       KeyRight,
  input  logic       LockSwitch,
  output logic [5:0] cursorIdx,
  output logic [5:0] selectIdx,
  output logic [1:0] selectType,
  output logic       moveValid,
  output logic [5:0] moveFrom,
  output logic [5:0] moveTo,
  input  logic       moveReady
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] INV = {1'b0, {4{KEY_ACTIVE_LOW != 0}}};
  typedef enum logic [1:0] {IDLE, SELECTED, MOVE_REQ} state_t;
  state_t state;
  logic [4:0] raw, sync1, sync2, norm, stable, flip, rise;
  logic lockFall;
  logic [CW-1:0] cnt [5];
  logic [2:0] row, col;
  logic [5:0] curNext;
  // bit order: 0 up, 1 down, 2 left, 3 right, 4 lock
  assign raw = {LockSwitch, KeyRight, KeyLeft, KeyDown, KeyUp};
  assign norm = sync2 ^ INV;
  assign row = cursorIdx[5:3];
  assign col = cursorIdx[2:0];
  // priority Up > Down > Left > Right; an edge press leaves the cursor where it is
  assign curNext = rise[0] ? (row != 3'd0 ? cursorIdx - 6'd8 : cursorIdx) :
                   rise[1] ? (row != 3'd7 ? cursorIdx + 6'd8 : cursorIdx) :
                   rise[2] ? (col != 3'd0 ? cursorIdx - 6'd1 : cursorIdx) :
                   rise[3] ? (col != 3'd7 ? cursorIdx + 6'd1 : cursorIdx) : cursorIdx;
  // a level flips once it has differed from the stable level long enough
  always_comb begin
    flip = '0;
    for (int i = 0; i < 5; i++) flip[i] = (norm[i] != stable[i]) && (cnt[i] == LAST);
  end
  // synchronisers, debounce counters and one-cycle edge pulses
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      sync1 <= INV;
      sync2 <= INV;
      stable <= '0;
      rise <= '0;
      lockFall <= 1'b0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      stable <= stable ^ flip;
      rise <= flip & ~stable;
      lockFall <= flip[4] & stable[4];
      for (int i = 0; i < 5; i++) cnt[i] <= (norm[i] != stable[i] && !flip[i]) ? cnt[i] + 1'b1 : '0;
    end
  end
  // cursor, selection and move-request state machine
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state <= IDLE;
      cursorIdx <= CURSOR_INIT;
      selectIdx <= 6'd0;
      selectType <= 2'd0;
      moveValid <= 1'b0;
      moveFrom <= 6'd0;
      moveTo <= 6'd0;
    end else if (!enable) begin
      state <= IDLE;
      moveValid <= 1'b0;
      selectType <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          cursorIdx <= curNext;
          selectType <= rise[4] ? 2'd2 : 2'd1;
          if (rise[4]) begin
            selectIdx <= cursorIdx;
            state <= SELECTED;
          end
        end
        SELECTED: begin
          cursorIdx <= lockFall ? cursorIdx : curNext;
          selectType <= (lockFall && cursorIdx == selectIdx) ? 2'd1 : 2'd2;
          if (lockFall && cursorIdx == selectIdx) state <= IDLE;
          else if (lockFall) begin
            moveValid <= 1'b1;
            moveFrom <= selectIdx;
            moveTo <= cursorIdx;
            state <= MOVE_REQ;
          end
        end
        default: begin
          selectType <= moveReady ? 2'd1 : 2'd2;
          if (moveReady) begin
            moveValid <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chess_cursor_ctrl.sv
// tb_chess_cursor_ctrl: table-driven cursor checks plus hand-written select/move/abort/reset sequences
module tb_chess_cursor_ctrl;
  logic clock = 1'b0;
  logic resetApp = 1'b1;
  logic enable = 1'b1;
  logic KeyLeft = 1'b1, KeyUp = 1'b1, KeyDown = 1'b1, KeyRight = 1'b1;
  logic LockSwitch = 1'b0;
  logic moveReady = 1'b0;
  logic [5:0] cursorIdx, selectIdx, moveFrom, moveTo;
  logic [1:0] selectType;
  logic moveValid;
  int checks = 0, errors = 0;

  typedef struct {
    logic [3:0] m;
    int hold;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[$];

  chess_cursor_ctrl #(.DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1), .CURSOR_INIT(6'd0)) dut (
    .clock(clock), .resetApp(resetApp), .enable(enable),
    .KeyLeft(KeyLeft), .KeyUp(KeyUp), .KeyDown(KeyDown), .KeyRight(KeyRight),
    .LockSwitch(LockSwitch), .cursorIdx(cursorIdx), .selectIdx(selectIdx),
    .selectType(selectType), .moveValid(moveValid), .moveFrom(moveFrom),
    .moveTo(moveTo), .moveReady(moveReady)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] m, input int hold, input logic [5:0] exp);
    vec_t v;
    v.m = m;
    v.hold = hold;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  // mask bits: 3 up, 2 down, 1 left, 0 right
  task automatic press(input logic [3:0] m, input int hold);
    @(negedge clock);
    {KeyUp, KeyDown, KeyLeft, KeyRight} = ~m;
    repeat (hold) @(negedge clock);
    {KeyUp, KeyDown, KeyLeft, KeyRight} = 4'b1111;
    repeat (12) @(negedge clock);
  endtask

  task automatic lock(input logic v);
    @(negedge clock);
    LockSwitch = v;
    repeat (12) @(negedge clock);
  endtask

  initial begin
    bit sawValid;
    add(4'b1000, 10, 6'd0);
    add(4'b0010, 10, 6'd0);
    add(4'b0001, 3, 6'd0);
    add(4'b0001, 10, 6'd1);
    add(4'b0100, 10, 6'd9);
    add(4'b1001, 10, 6'd1);
    add(4'b0010, 10, 6'd0);
    for (int i = 1; i <= 7; i++) add(4'b0100, 10, 6'(8 * i));
    for (int i = 1; i <= 7; i++) add(4'b0001, 10, 6'(56 + i));
    add(4'b0100, 10, 6'd63);
    add(4'b0001, 10, 6'd63);
    add(4'b1000, 10, 6'd55);
    add(4'b0010, 10, 6'd54);
    add(4'b0010, 10, 6'd53);
    add(4'b0010, 10, 6'd52);

    repeat (3) @(negedge clock);
    chk("reset cursorIdx", cursorIdx, 0);
    chk("reset selectType", selectType, 0);
    chk("reset moveValid", moveValid, 0);
    resetApp = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle selectType", selectType, 1);

    foreach (vecs[i]) begin
      press(vecs[i].m, vecs[i].hold);
      chk($sformatf("vec%0d cursorIdx", i), cursorIdx, vecs[i].exp);
    end

    lock(1'b1);
    chk("select selectType", selectType, 2);
    chk("select selectIdx", selectIdx, 52);
    press(4'b1000, 10);
    press(4'b1000, 10);
    chk("selected cursorIdx", cursorIdx, 36);
    chk("pre-release moveValid", moveValid, 0);
    lock(1'b0);
    chk("move moveValid", moveValid, 1);
    chk("move moveFrom", moveFrom, 52);
    chk("move moveTo", moveTo, 36);
    press(4'b0010, 10);
    press(4'b1000, 10);
    chk("held moveValid", moveValid, 1);
    chk("held moveFrom", moveFrom, 52);
    chk("held moveTo", moveTo, 36);
    chk("held cursorIdx", cursorIdx, 36);
    chk("held selectType", selectType, 2);
    moveReady = 1'b1;
    @(negedge clock);
    moveReady = 1'b0;
    chk("done moveValid", moveValid, 0);
    chk("done selectType", selectType, 1);
    chk("done cursorIdx", cursorIdx, 36);

    press(4'b1000, 10);
    press(4'b1000, 10);
    chk("cancel start cursorIdx", cursorIdx, 20);
    lock(1'b1);
    chk("cancel selectType sel", selectType, 2);
    chk("cancel selectIdx", selectIdx, 20);
    @(negedge clock);
    LockSwitch = 1'b0;
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge clock);
      sawValid |= moveValid;
    end
    chk("cancel moveValid seen", int'(sawValid), 0);
    chk("cancel selectType", selectType, 1);

    lock(1'b1);
    press(4'b0001, 10);
    lock(1'b0);
    chk("abort pre moveValid", moveValid, 1);
    chk("abort pre moveTo", moveTo, 21);
    enable = 1'b0;
    @(negedge clock);
    chk("abort moveValid", moveValid, 0);
    chk("abort selectType", selectType, 0);
    chk("abort cursorIdx", cursorIdx, 21);
    press(4'b1000, 10);
    press(4'b0010, 10);
    lock(1'b1);
    chk("disabled cursorIdx", cursorIdx, 21);
    chk("disabled moveValid", moveValid, 0);
    enable = 1'b1;
    repeat (2) @(negedge clock);
    chk("reenable selectType", selectType, 1);
    lock(1'b0);
    chk("reenable no select", selectType, 1);

    lock(1'b1);
    chk("pre-reset selectType", selectType, 2);
    chk("pre-reset selectIdx", selectIdx, 21);
    #2 resetApp = 1'b1;
    #1;
    chk("async cursorIdx", cursorIdx, 0);
    chk("async selectIdx", selectIdx, 0);
    chk("async selectType", selectType, 0);
    chk("async moveValid", moveValid, 0);
    @(negedge clock);
    LockSwitch = 1'b0;
    resetApp = 1'b0;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
